// File: rtl/sw_port_pkg.sv
// Shared constants for the Minisys-1 switch input port: halfword register indices
// within the port window and bit positions inside the ctrl and status registers.
package sw_port_pkg;

    localparam logic [2:0] ADDR_STABLE_LO = 3'd0;
    localparam logic [2:0] ADDR_STABLE_HI = 3'd1;
    localparam logic [2:0] ADDR_PEND_LO   = 3'd2;
    localparam logic [2:0] ADDR_PEND_HI   = 3'd3;
    localparam logic [2:0] ADDR_CTRL      = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int STATUS_PEND_BIT  = 0;
    localparam int STATUS_BUSY_BIT  = 1;

    typedef logic [15:0] half_t;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch input: two-flop synchroniser, persistence counter and stable level.
// change_o pulses on the edge where stable_o takes the new level.
module switch_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic switclk,
    input  logic switrst,
    input  logic raw_i,
    output logic stable_o,
    output logic change_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any agreement between sync and stable restarts the persistence window.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        change_o = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                change_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge switclk or posedge switrst) begin
        if (switrst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign busy_o   = (cnt_q != '0);

endmodule

// File: rtl/switch_port_debounced.sv
// Memory-mapped debounced switch port: stable levels, W1C change-pending registers,
// irq enable and a level interrupt, read as 16-bit halfwords on the CPU I/O bus.
module switch_port_debounced
    import sw_port_pkg::*;
#(
    parameter int NUM_BITS        = 24,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic                switclk,
    input  logic                switrst,
    input  logic                switchcs,
    input  logic                switchread,
    input  logic                switchwrite,
    input  logic [2:0]          switchaddr,
    input  logic [15:0]         switchwdata,
    output logic [15:0]         switchrdata,
    input  logic [NUM_BITS-1:0] switch_i,
    output logic                switchirq
);

    logic [31:0] stable_w;
    logic [31:0] change_w;
    logic [31:0] busy_w;

    // Bits at or above NUM_BITS are tied off so they read 0 and never pend.
    for (genvar i = 0; i < 32; i++) begin : g_bit
        if (i < NUM_BITS) begin : g_used
            switch_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_bit (
                .switclk (switclk),
                .switrst (switrst),
                .raw_i   (switch_i[i]),
                .stable_o(stable_w[i]),
                .change_o(change_w[i]),
                .busy_o  (busy_w[i])
            );
        end else begin : g_unused
            assign stable_w[i] = 1'b0;
            assign change_w[i] = 1'b0;
            assign busy_w[i]   = 1'b0;
        end
    end

    // Bus: strobes are qualified by switchcs, no backpressure; a write lands on the
    // posedge ending its cycle, a read is captured on the negedge inside it.
    logic        wr_en;
    logic        rd_en;
    logic [31:0] w1c_mask;
    logic [31:0] pending_q, pending_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
    half_t       rd_mux;
    half_t       rdata_q, rdata_d;

    assign wr_en = switchcs & switchwrite;
    assign rd_en = switchcs & switchread;

    // A change event on the same edge as a W1C write keeps the bit set.
    always_comb begin
        w1c_mask = '0;
        if (wr_en && switchaddr == ADDR_PEND_LO) w1c_mask[15:0]  = switchwdata;
        if (wr_en && switchaddr == ADDR_PEND_HI) w1c_mask[31:16] = switchwdata;
        pending_d = (pending_q & ~w1c_mask) | change_w;

        irq_en_d = irq_en_q;
        if (wr_en && switchaddr == ADDR_CTRL) irq_en_d = switchwdata[CTRL_IRQ_EN_BIT];

        irq_d = irq_en_q & (|pending_q);
    end

    always_comb begin
        rd_mux = '0;
        case (switchaddr)
            ADDR_STABLE_LO: rd_mux = stable_w[15:0];
            ADDR_STABLE_HI: rd_mux = stable_w[31:16];
            ADDR_PEND_LO:   rd_mux = pending_q[15:0];
            ADDR_PEND_HI:   rd_mux = pending_q[31:16];
            ADDR_CTRL:      rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
            ADDR_STATUS: begin
                rd_mux[STATUS_PEND_BIT] = |pending_q;
                rd_mux[STATUS_BUSY_BIT] = |busy_w;
            end
            default:        rd_mux = '0;
        endcase
        rdata_d = rd_en ? rd_mux : rdata_q;
    end

    always_ff @(posedge switclk or posedge switrst) begin
        if (switrst) begin
            pending_q <= '0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    // Read data is launched on the falling edge to meet the CPU I/O read timing.
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) rdata_q <= '0;
        else         rdata_q <= rdata_d;
    end

    assign switchrdata = rdata_q;
    assign switchirq   = irq_q;

endmodule

// File: tb/tb_switch_port_debounced.sv
// Bench for switch_port_debounced with DEBOUNCE_CYCLES=4 and NUM_BITS=24:
// reads go through an expected-value queue, irq and reset values are checked directly.
module tb_switch_port_debounced;

    logic        switclk;
    logic        switrst;
    logic        switchcs;
    logic        switchread;
    logic        switchwrite;
    logic [2:0]  switchaddr;
    logic [15:0] switchwdata;
    logic [15:0] switchrdata;
    logic [23:0] switch_i;
    logic        switchirq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    switch_port_debounced #(
        .NUM_BITS       (24),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .switclk    (switclk),
        .switrst    (switrst),
        .switchcs   (switchcs),
        .switchread (switchread),
        .switchwrite(switchwrite),
        .switchaddr (switchaddr),
        .switchwdata(switchwdata),
        .switchrdata(switchrdata),
        .switch_i   (switch_i),
        .switchirq  (switchirq)
    );

    // ---------------- clock / reset ----------------
    initial switclk = 1'b0;
    always #5 switclk = ~switclk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge switclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rd(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        switchcs   = 1'b1;
        switchread = 1'b1;
        switchaddr = addr;
        @(negedge switclk);
        #1;
        check_eq(tag_q.pop_front(), {16'h0, switchrdata}, {16'h0, exp_q.pop_front()});
        @(posedge switclk);
        #1;
        switchcs   = 1'b0;
        switchread = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        switchcs    = 1'b1;
        switchwrite = 1'b1;
        switchaddr  = addr;
        switchwdata = data;
        @(posedge switclk);
        #1;
        switchcs    = 1'b0;
        switchwrite = 1'b0;
        switchwdata = 16'h0;
    endtask

    task automatic rdwr(input logic [2:0] addr, input logic [15:0] data,
                        input logic [15:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        switchcs    = 1'b1;
        switchread  = 1'b1;
        switchwrite = 1'b1;
        switchaddr  = addr;
        switchwdata = data;
        @(negedge switclk);
        #1;
        check_eq(tag_q.pop_front(), {16'h0, switchrdata}, {16'h0, exp_q.pop_front()});
        @(posedge switclk);
        #1;
        switchcs    = 1'b0;
        switchread  = 1'b0;
        switchwrite = 1'b0;
        switchwdata = 16'h0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        switrst     = 1'b1;
        switchcs    = 1'b0;
        switchread  = 1'b0;
        switchwrite = 1'b0;
        switchaddr  = 3'd0;
        switchwdata = 16'h0;
        switch_i    = 24'hFF_FFFF;

        // Reset held with all switches high.
        ticks(3);
        check_eq("rst_rdata", {16'h0, switchrdata}, 32'h0);
        check_eq("rst_irq", {31'h0, switchirq}, 32'h0);
        switrst = 1'b0;
        rd(3'd0, 16'h0000, "rst_first_read_lo");
        ticks(8);
        rd(3'd0, 16'hFFFF, "all_hi_lo");
        rd(3'd1, 16'h00FF, "all_hi_hi_ext");
        rd(3'd2, 16'hFFFF, "all_hi_pend_lo");
        rd(3'd3, 16'h00FF, "all_hi_pend_hi");
        rd(3'd5, 16'h0001, "all_hi_status");
        check_eq("all_hi_irq_dis", {31'h0, switchirq}, 32'h0);

        // Back to all low, then clear every pending bit.
        switch_i = 24'h0;
        ticks(8);
        rd(3'd0, 16'h0000, "all_lo_lo");
        wr(3'd2, 16'hFFFF);
        wr(3'd3, 16'hFFFF);
        rd(3'd2, 16'h0000, "clr_pend_lo");
        rd(3'd3, 16'h0000, "clr_pend_hi");
        rd(3'd6, 16'h0000, "addr6_zero");
        rd(3'd7, 16'h0000, "addr7_zero");
        rd(3'd5, 16'h0000, "idle_status");

        // Clean step: stable must flip on exactly the 6th posedge.
        switch_i = 24'hA5_1234;
        ticks(5);
        rd(3'd0, 16'h0000, "step_pre6");
        rd(3'd0, 16'h1234, "step_lo");
        rd(3'd1, 16'h00A5, "step_hi");
        rd(3'd2, 16'h1234, "step_pend_lo");
        rd(3'd3, 16'h00A5, "step_pend_hi");
        rd(3'd5, 16'h0001, "step_status");
        wr(3'd2, 16'hFFFF);
        wr(3'd3, 16'hFFFF);
        rd(3'd2, 16'h0000, "step_clr_lo");

        // Glitch of 3 cycles on bit3.
        switch_i[3] = 1'b1;
        ticks(3);
        switch_i[3] = 1'b0;
        rd(3'd5, 16'h0002, "glitch_busy");
        ticks(6);
        rd(3'd0, 16'h1234, "glitch_stable");
        rd(3'd2, 16'h0000, "glitch_pend");
        rd(3'd5, 16'h0000, "glitch_status");

        // IRQ enable and W1C clear.
        wr(3'd4, 16'hFFFF);
        rd(3'd4, 16'h0001, "ctrl_readback");
        check_eq("irq_idle", {31'h0, switchirq}, 32'h0);
        switch_i[0] = 1'b1;
        ticks(6);
        check_eq("irq_same_edge", {31'h0, switchirq}, 32'h0);
        tick();
        check_eq("irq_set", {31'h0, switchirq}, 32'h1);
        rd(3'd2, 16'h0001, "irq_pend");
        wr(3'd2, 16'h0001);
        check_eq("irq_hold_wr_edge", {31'h0, switchirq}, 32'h1);
        tick();
        check_eq("irq_clr", {31'h0, switchirq}, 32'h0);
        rd(3'd2, 16'h0000, "irq_pend_clr");

        // Collision: W1C on bit5 at the edge its debounce completes.
        switch_i[5] = 1'b0;
        ticks(5);
        wr(3'd2, 16'h0020);
        tick();
        check_eq("coll_irq", {31'h0, switchirq}, 32'h1);
        rd(3'd0, 16'h1215, "coll_stable");
        rdwr(3'd2, 16'h0020, 16'h0020, "rdwr_prewrite");
        rd(3'd2, 16'h0000, "rdwr_cleared");

        // Async reset while bit1 is mid-debounce.
        switch_i[1] = 1'b1;
        ticks(3);
        rd(3'd5, 16'h0002, "mid_busy");
        switrst = 1'b1;
        #2;
        switrst = 1'b0;
        check_eq("mid_rst_rdata", {16'h0, switchrdata}, 32'h0);
        check_eq("mid_rst_irq", {31'h0, switchirq}, 32'h0);
        rd(3'd5, 16'h0000, "mid_rst_status");
        rd(3'd2, 16'h0000, "mid_rst_pend");
        ticks(3);
        rd(3'd0, 16'h0000, "redeb_pre");
        rd(3'd0, 16'h1217, "redeb_lo");
        rd(3'd1, 16'h00A5, "redeb_hi");
        rd(3'd2, 16'h1217, "redeb_pend");
        rd(3'd4, 16'h0000, "redeb_ctrl");
        check_eq("redeb_irq", {31'h0, switchirq}, 32'h0);

        // ---------------- report ----------------
        check_eq("sb_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
